// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive and transmit paths: state encoding,
// parity-mode constants and the three-point majority vote.
package uart_pkg;

    localparam logic [4:0] ST_IDLE   = 5'd0;
    localparam logic [4:0] ST_START  = 5'd1;
    localparam logic [4:0] ST_DATA   = 5'd2;
    localparam logic [4:0] ST_PARITY = 5'd3;
    localparam logic [4:0] ST_STOP1  = 5'd4;
    localparam logic [4:0] ST_STOP2  = 5'd5;

    typedef enum logic [4:0] {
        IDLE   = ST_IDLE,
        START  = ST_START,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP1  = ST_STOP1,
        STOP2  = ST_STOP2
    } rx_state_t;

    // Mode 2'b11 is also treated as no parity.
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Oversample tick generator: one-clock tick every div+1 clocks; clear restarts
// the phase so the next clock carries a tick.
module uart_tick_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (cnt == '0) begin
            cnt <= div;
        end else begin
            cnt <= cnt - DIV_W'(1);
        end
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: majority-voted oversampling, runtime parity and
// stop-bit selection, held output word with valid/ready and overrun flag.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OVS    = 16,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rx_en,
    input  logic              rxd,
    input  logic [DIV_W-1:0]  baud_div,
    input  logic [1:0]        parity_mode,
    input  logic              stop2,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_ferror,
    output logic              rx_perror,
    output logic              rx_overrun
);

    localparam int TCW = $clog2(OVS);
    localparam int BCW = $clog2(DATA_W);

    localparam logic [TCW-1:0] T_S0   = TCW'(OVS / 2 - 1);
    localparam logic [TCW-1:0] T_S1   = TCW'(OVS / 2);
    localparam logic [TCW-1:0] T_VOTE = TCW'(OVS / 2 + 1);
    localparam logic [TCW-1:0] T_END  = TCW'(OVS - 1);
    localparam logic [BCW-1:0] B_LAST = BCW'(DATA_W - 1);

    rx_state_t         state, state_n;
    logic              rxd_meta, rxs;
    logic [TCW-1:0]    tcnt;
    logic [BCW-1:0]    bcnt;
    logic [DATA_W-1:0] sr;
    logic              samp0, samp1;
    logic              par_err, fr_err;
    logic [1:0]        mode_q;
    logic              stop2_q;
    logic [DIV_W-1:0]  div_q;
    logic              tick, tick_clear;
    logic              at_vote, at_end, voted, par_en;
    logic              frame_done, frame_ferr;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rxd_meta <= 1'b1;
            rxs      <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxs      <= rxd_meta;
        end
    end

    uart_tick_gen #(.DIV_W(DIV_W)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (tick_clear),
        .div     (div_q),
        .tick    (tick)
    );

    assign at_vote    = tick && (tcnt == T_VOTE);
    assign at_end     = tick && (tcnt == T_END);
    assign voted      = maj3(samp0, samp1, rxs);
    assign par_en     = (mode_q == PAR_EVEN) || (mode_q == PAR_ODD);
    assign frame_ferr = fr_err | ~voted;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    // NOTE: every combinational output gets a default first so no path
    // through the case can infer a latch.
    always_comb begin
        state_n    = state;
        tick_clear = 1'b0;
        frame_done = 1'b0;
        if (!rx_en && state != IDLE) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (rx_en && !rxs) begin
                        state_n    = START;
                        tick_clear = 1'b1;
                    end
                end
                START: begin
                    if (at_vote && voted) state_n = IDLE;
                    else if (at_end)      state_n = DATA;
                end
                DATA: begin
                    if (at_end && bcnt == B_LAST) state_n = par_en ? PARITY : STOP1;
                end
                PARITY: begin
                    if (at_end) state_n = STOP1;
                end
                STOP1: begin
                    if (stop2_q) begin
                        if (at_end) state_n = STOP2;
                    end else if (at_vote) begin
                        state_n    = IDLE;
                        frame_done = 1'b1;
                    end
                end
                STOP2: begin
                    if (at_vote) begin
                        state_n    = IDLE;
                        frame_done = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tcnt    <= '0;
            bcnt    <= '0;
            sr      <= '0;
            samp0   <= 1'b1;
            samp1   <= 1'b1;
            par_err <= 1'b0;
            fr_err  <= 1'b0;
            mode_q  <= PAR_NONE;
            stop2_q <= 1'b0;
            div_q   <= '0;
        end else if (state == IDLE) begin
            tcnt    <= '0;
            bcnt    <= '0;
            sr      <= '0;
            par_err <= 1'b0;
            fr_err  <= 1'b0;
            mode_q  <= parity_mode;
            stop2_q <= stop2;
            div_q   <= baud_div;
        end else if (tick) begin
            tcnt <= (tcnt == T_END) ? '0 : tcnt + TCW'(1);
            if (tcnt == T_S0) samp0 <= rxs;
            if (tcnt == T_S1) samp1 <= rxs;
            if (tcnt == T_VOTE) begin
                case (state)
                    DATA:   sr <= {voted, sr[DATA_W-1:1]};
                    PARITY: par_err <= (mode_q == PAR_EVEN) ? (voted != ^sr)
                                                            : (voted != ~^sr);
                    STOP1, STOP2: if (!voted) fr_err <= 1'b1;
                    default: ;
                endcase
            end
            if (tcnt == T_END && state == DATA) bcnt <= bcnt + BCW'(1);
        end
    end

    // A completing frame takes priority; a free register may be freed and
    // reloaded in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_ferror  <= 1'b0;
            rx_perror  <= 1'b0;
            rx_overrun <= 1'b0;
        end else if (frame_done) begin
            if (!rx_valid || rx_ready) begin
                rx_data    <= sr;
                rx_ferror  <= frame_ferr;
                rx_perror  <= par_err;
                rx_valid   <= 1'b1;
                rx_overrun <= 1'b0;
            end else begin
                rx_overrun <= 1'b1;
            end
        end else if (rx_valid && rx_ready) begin
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end
    end

endmodule
